// File: rtl/s_axis_kernel_remapper.sv
// ============================================================================
// Module   : s_axis_kernel_remapper
// Function : Collects a tap-interleaved AXI4-Stream into ping-pong kernels and
//            presents each one transposed into linear pixel order.
// Option   : KERNEL_SOF_RESYNC_EN - tuser restarts a partially filled kernel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module s_axis_kernel_remapper #(
  parameter int DATA_WIDTH       = 8,
  parameter int IMAGE_KERNEL_12K = 64,
  parameter int NUM_TAPS         = 8
) (
  input  logic                                         i_clk,
  input  logic                                         i_aresetn,
  input  logic [DATA_WIDTH-1:0]                        s_axis_tdata,
  input  logic                                         s_axis_tvalid,
  output logic                                         s_axis_tready,
  input  logic                                         s_axis_tuser,
  input  logic                                         s_axis_tlast,
  output logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0]  o_image_kernel_remapped,
  output logic                                         o_kernel_is_remapped,
  output logic                                         o_line_err
);

  localparam int             c_AW   = $clog2(IMAGE_KERNEL_12K);
  localparam int             c_ROWS = IMAGE_KERNEL_12K / NUM_TAPS;
  localparam logic [c_AW-1:0] c_LAST = c_AW'(IMAGE_KERNEL_12K - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} state_t;

  state_t                                        r_state, w_state_nxt;
  logic [c_AW-1:0]                               r_fill_idx;
  logic                                          r_fill_bank;
  logic [1:0]                                    r_full;
  logic                                          r_pres_bank, w_pres_bank_nxt;
  logic [c_AW-1:0]                               r_pres_cnt, w_pres_cnt_nxt;
  logic                                          r_line_err;
  logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0]   r_bank [2];

  logic            w_accept;
  logic            w_resync;
  logic [c_AW-1:0] w_idx;
  logic [c_AW-1:0] w_addr;
  logic            w_wrap;
  logic            w_win_end;
  logic [1:0]      w_full_nxt;

  assign w_accept = s_axis_tvalid && s_axis_tready;

`ifdef KERNEL_SOF_RESYNC_EN
  assign w_resync = w_accept && s_axis_tuser && (r_fill_idx != '0);
`else
  logic w_tuser_unused;
  assign w_tuser_unused = s_axis_tuser;
  assign w_resync       = 1'b0;
`endif

  // Transposed write address: tap-major in the stream, pixel-major in the bank.
  assign w_idx     = w_resync ? '0 : r_fill_idx;
  assign w_addr    = c_AW'((int'(w_idx) % NUM_TAPS) * c_ROWS + int'(w_idx) / NUM_TAPS);
  assign w_wrap    = w_accept && (w_idx == c_LAST);
  assign w_win_end = (r_state == ST_PRESENT) && (r_pres_cnt == c_LAST);

  // A bank freed at window end is fillable on the very next cycle.
  always_comb begin
    w_full_nxt = r_full;
    if (w_win_end) w_full_nxt[r_pres_bank] = 1'b0;
    if (w_wrap)    w_full_nxt[r_fill_bank] = 1'b1;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pres_bank_nxt = r_pres_bank;
    w_pres_cnt_nxt  = r_pres_cnt + c_AW'(1);
    case (r_state)
      ST_IDLE: begin
        w_pres_cnt_nxt = '0;
        if (w_wrap) begin
          w_state_nxt     = ST_PRESENT;
          w_pres_bank_nxt = r_fill_bank;
        end
      end
      ST_PRESENT: begin
        if (w_win_end) begin
          w_pres_cnt_nxt = '0;
          if (w_full_nxt[~r_pres_bank]) w_pres_bank_nxt = ~r_pres_bank;
          else                          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state     <= ST_IDLE;
      r_pres_bank <= 1'b0;
      r_pres_cnt  <= '0;
      r_fill_idx  <= '0;
      r_fill_bank <= 1'b0;
      r_full      <= 2'b00;
      r_line_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pres_bank <= w_pres_bank_nxt;
      r_pres_cnt  <= w_pres_cnt_nxt;
      r_full      <= w_full_nxt;
      if (w_accept) begin
        r_fill_idx <= w_idx + c_AW'(1);
        if (w_wrap) r_fill_bank <= ~r_fill_bank;
        if (s_axis_tlast && (w_idx != c_LAST)) r_line_err <= 1'b1;
      end
    end
  end

  // Pixel storage carries no reset; validity lives in r_full and r_state.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_bank[r_fill_bank][w_addr] <= s_axis_tdata;
  end

  assign s_axis_tready           = !r_full[r_fill_bank];
  assign o_kernel_is_remapped    = (r_state == ST_PRESENT);
  assign o_image_kernel_remapped = (r_state == ST_PRESENT) ? r_bank[r_pres_bank] : '0;
  assign o_line_err              = r_line_err;

endmodule

`default_nettype wire

// File: tb/tb_s_axis_kernel_remapper.sv
// ============================================================================
// Module   : tb_s_axis_kernel_remapper
// Function : Randomized scoreboard bench for s_axis_kernel_remapper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_s_axis_kernel_remapper;

  localparam int DW = 8;
  localparam int K  = 64;
  localparam int T  = 8;

  typedef logic [0:K-1][DW-1:0] kern_t;

  logic          i_clk = 1'b0;
  logic          i_aresetn = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          tuser = 1'b0;
  logic          tlast = 1'b0;
  kern_t         kout;
  logic          flag;
  logic          err;

  always #5 i_clk = ~i_clk;

  s_axis_kernel_remapper #(
    .DATA_WIDTH      (DW),
    .IMAGE_KERNEL_12K(K),
    .NUM_TAPS        (T)
  ) dut (
    .i_clk                  (i_clk),
    .i_aresetn              (i_aresetn),
    .s_axis_tdata           (tdata),
    .s_axis_tvalid          (tvalid),
    .s_axis_tready          (tready),
    .s_axis_tuser           (tuser),
    .s_axis_tlast           (tlast),
    .o_image_kernel_remapped(kout),
    .o_kernel_is_remapped   (flag),
    .o_line_err             (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [K*DW-1:0] act, input logic [K*DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference model: pixels of the kernel in arrival order, completed kernels
  // in presentation order, and the cycle each kernel completed.
  logic [DW-1:0] cur[$];
  kern_t         exp_q[$];
  int            done_q[$];
  int            cyc = 0;
  bit            err_exp = 1'b0;

  function automatic kern_t transpose(input logic [DW-1:0] px[$]);
    kern_t k;
    k = '0;
    for (int i = 0; i < K; i++) k[(i % T) * (K / T) + i / T] = px[i];
    return k;
  endfunction

  always @(posedge i_clk) begin
    cyc++;
    if (i_aresetn && tvalid && tready) begin
`ifdef KERNEL_SOF_RESYNC_EN
      if (tuser && cur.size() != 0) cur.delete();
`endif
      if (tlast && cur.size() != K - 1) err_exp = 1'b1;
      cur.push_back(tdata);
      if (cur.size() == K) begin
        exp_q.push_back(transpose(cur));
        done_q.push_back(cyc);
        cur.delete();
      end
    end
  end

  // Monitor: windows are K cycles long; each consumes one expected kernel.
  int    wcnt = 0;
  bit    prev_flag = 1'b0;
  kern_t cur_exp = '0;

  always @(negedge i_clk) begin : mon
    int held;
    int dc;
    if (!i_aresetn) begin
      wcnt      = 0;
      prev_flag = 1'b0;
    end else begin
      chk("line_err", err, err_exp);
      held = exp_q.size() + ((flag && wcnt != 0) ? 1 : 0);
      chk("tready", tready, (held < 2));
      if (flag) begin
        if (wcnt == 0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_window: got flag=1 expected no pending kernel");
          end else begin
            cur_exp = exp_q.pop_front();
            dc      = done_q.pop_front();
            if (!prev_flag) chk("latency", cyc, dc);
          end
        end
        chk("window_data", kout, cur_exp);
        wcnt = (wcnt + 1) % K;
      end else begin
        chk("idle_pending", exp_q.size(), 0);
        chk("window_short", wcnt, 0);
        chk("idle_data", kout, 0);
      end
      prev_flag = flag;
    end
  end

  task automatic send(input logic [DW-1:0] d, input bit u, input bit l);
    int guard;
    guard  = 0;
    tdata  = d;
    tuser  = u;
    tlast  = l;
    tvalid = 1'b1;
    while (!tready && guard < 1000) begin
      @(negedge i_clk);
      guard++;
    end
    if (!tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got tready=0 expected 1 within 1000 cycles");
    end
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #2;
    i_aresetn = 1'b0;
    tvalid    = 1'b0;
    tuser     = 1'b0;
    tlast     = 1'b0;
    cur.delete();
    exp_q.delete();
    done_q.delete();
    err_exp = 1'b0;
    #1;
    chk("async_flag", flag, 0);
    chk("async_data", kout, 0);
    repeat (3) @(negedge i_clk);
    i_aresetn = 1'b1;
    @(negedge i_clk);
    chk("rst_tready", tready, 1);
    chk("rst_flag", flag, 0);
    chk("rst_err", err, 0);
    chk("rst_data", kout, 0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    idle(1);
    while ((exp_q.size() != 0 || flag) && guard < 4 * K + 10) begin
      @(negedge i_clk);
      guard++;
    end
    if (exp_q.size() != 0 || flag) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got pending=%0d flag=%0b expected 0 0", exp_q.size(), flag);
    end
  endtask

  task automatic rand_kernels(input int n, input bit gaps);
    for (int i = 0; i < n * K; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle(1);
      send(DW'($urandom), (i % K) == 0, (i % K) == K - 1);
    end
  endtask

  initial begin
    do_reset();

    // Ramp kernel with directed entry checks
    for (int i = 0; i < K; i++) send(DW'(i), i == 0, i == K - 1);
    chk("ramp_flag", flag, 1);
    chk("ramp_e1", kout[1], 8);
    chk("ramp_e8", kout[8], 1);
    chk("ramp_e63", kout[63], 63);
    drain();

    // Sustained and gapped streams
    rand_kernels(4, 1'b0);
    drain();
    rand_kernels(3, 1'b1);
    drain();

    // Line error is sticky; a well-formed line leaves it clear
    do_reset();
    for (int i = 0; i < K; i++) send(DW'($urandom), i == 0, i == 30);
    drain();
    chk("line_err_set", err, 1);
    idle(5);
    chk("line_err_sticky", err, 1);
    do_reset();
    for (int i = 0; i < K; i++) send(DW'($urandom), i == 0, i == K - 1);
    drain();
    chk("line_err_clean", err, 0);

    // Start of frame in the middle of a kernel
    do_reset();
    for (int i = 0; i < 20; i++) send(DW'($urandom), i == 0, 1'b0);
    send(8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < K - 1; i++) send(DW'($urandom), 1'b0, i == K - 2);
    drain();

    // Reset while a window is active, then a fresh kernel
    for (int i = 0; i < K; i++) send(DW'($urandom), i == 0, i == K - 1);
    idle(5);
    do_reset();
    rand_kernels(1, 1'b0);
    drain();

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
